// File: rtl/pio_output_shift.sv
// Output shift register of a PIO state machine: shifts 1-32 bits per tick toward
// the pin mapper and autopulls fresh words from the TX FIFO when the threshold is hit.
module pio_output_shift (
    input  logic        clock,
    input  logic        reset,
    input  logic        tick,
    input  logic        clear,
    input  logic        shift_dir,
    input  logic [5:0]  out_bits,
    input  logic        autopull_en,
    input  logic [5:0]  thresh,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic        stall,
    output logic [5:0]  shift_count
);

    // Encoded widths of 0 or above 32 both mean a full 32-bit word.
    function automatic logic [5:0] eff_width(input logic [5:0] w);
        return ((w == 6'd0) || (w > 6'd32)) ? 6'd32 : w;
    endfunction

    logic [31:0] osr_reg, osr_next;
    logic [5:0]  count_reg, count_next;
    logic        pending_reg, pending_next;
    logic [31:0] out_data_reg, out_data_next;
    logic        out_valid_reg, out_valid_next;

    logic [5:0]  n_eff;
    logic [5:0]  t_eff;
    logic        need_refill;
    logic        load;
    logic        req;
    logic        do_shift;
    logic [6:0]  count_sum;
    logic [5:0]  count_sat;
    logic [31:0] right_mask;
    logic [31:0] shifted_out;
    logic [31:0] shifted_osr;

    assign n_eff       = eff_width(out_bits);
    assign t_eff       = eff_width(thresh);
    assign need_refill = autopull_en && (count_reg >= t_eff);
    assign tx_ready    = need_refill && reset;
    assign load        = tx_valid && tx_ready;
    assign req         = tick || pending_reg;
    assign do_shift    = req && !need_refill;

    // Right-shift mask built bitwise so that n=32 selects the whole word exactly.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_mask
            assign right_mask[gi] = (6'(gi) < n_eff);
        end
    endgenerate

    // Shift amounts of 32 on a 32-bit operand yield zero, giving an empty OSR.
    assign shifted_out = shift_dir ? (osr_reg & right_mask)
                                   : (osr_reg >> (6'd32 - n_eff));
    assign shifted_osr = shift_dir ? (osr_reg >> n_eff) : (osr_reg << n_eff);

    assign count_sum = {1'b0, count_reg} + {1'b0, n_eff};
    assign count_sat = (count_sum > 7'd32) ? 6'd32 : count_sum[5:0];

    // Refill and shift never coincide: one needs need_refill, the other its inverse.
    always_comb begin
        osr_next       = osr_reg;
        count_next     = count_reg;
        pending_next   = pending_reg;
        out_data_next  = out_data_reg;
        out_valid_next = 1'b0;
        if (load) begin
            osr_next   = tx_data;
            count_next = 6'd0;
        end
        if (req) begin
            pending_next = need_refill;
        end
        if (do_shift) begin
            osr_next       = shifted_osr;
            count_next     = count_sat;
            out_data_next  = shifted_out;
            out_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            osr_reg       <= 32'd0;
            count_reg     <= 6'd32;
            pending_reg   <= 1'b0;
            out_data_reg  <= 32'd0;
            out_valid_reg <= 1'b0;
        end else begin
            osr_reg       <= osr_next;
            count_reg     <= count_next;
            pending_reg   <= pending_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;
    assign stall       = pending_reg && need_refill;
    assign shift_count = count_reg;

endmodule

// File: tb/tb_pio_output_shift.sv
// Bench for pio_output_shift: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a bit-queue reference model.
module tb_pio_output_shift;

    logic        clock = 1'b0;
    logic        reset;
    logic        tick;
    logic        clear;
    logic        shift_dir;
    logic [5:0]  out_bits;
    logic        autopull_en;
    logic [5:0]  thresh;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        stall;
    logic [5:0]  shift_count;

    always #5 clock = ~clock;

    pio_output_shift dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .clear       (clear),
        .shift_dir   (shift_dir),
        .out_bits    (out_bits),
        .autopull_en (autopull_en),
        .thresh      (thresh),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .stall       (stall),
        .shift_count (shift_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] fifo[$];
    bit          valid_gate = 1'b0;

    // Reference model: the OSR is a queue of 32 bits, index 0 = MSB.
    bit          m_bits[$];
    int          m_count = 32;
    bit          m_pending = 1'b0;
    logic [31:0] m_out_data = 32'd0;
    bit          m_out_valid = 1'b0;
    bit          model_live = 1'b0;

    logic [31:0] cap_data[$];
    int          cap_cnt[$];

    function automatic int eff(input logic [5:0] w);
        return ((w == 6'd0) || (w > 6'd32)) ? 32 : int'(w);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int n;
        int t;
        bit need;
        bit ld;
        bit rq;
        logic [31:0] w;
        logic [31:0] v;
        t = eff(thresh);
        n = eff(out_bits);
        need = autopull_en && (m_count >= t);
        ld = reset && need && tx_valid;
        w = 32'd0;
        if (ld && fifo.size() > 0) w = fifo.pop_front();
        if (!reset || clear) begin
            m_bits.delete();
            repeat (32) m_bits.push_back(1'b0);
            m_count = 32;
            m_pending = 1'b0;
            m_out_data = 32'd0;
            m_out_valid = 1'b0;
        end else begin
            m_out_valid = 1'b0;
            rq = tick || m_pending;
            if (ld) begin
                m_bits.delete();
                for (int i = 31; i >= 0; i--) m_bits.push_back(w[i]);
                m_count = 0;
            end
            if (rq && need) begin
                m_pending = 1'b1;
            end else if (rq) begin
                v = 32'd0;
                for (int k = 0; k < n; k++) begin
                    if (!shift_dir) begin
                        v = {v[30:0], m_bits.pop_front()};
                        m_bits.push_back(1'b0);
                    end else begin
                        v[k] = m_bits.pop_back();
                        m_bits.push_front(1'b0);
                    end
                end
                m_pending = 1'b0;
                m_out_data = v;
                m_out_valid = 1'b1;
                m_count = (m_count + n > 32) ? 32 : m_count + n;
            end
        end
        model_live = 1'b1;
    endtask

    task automatic drive_fifo();
        tx_valid = valid_gate && (fifo.size() > 0);
        tx_data  = (fifo.size() > 0) ? fifo[0] : 32'd0;
    endtask

    // One clock: present inputs, let the edge happen, advance the model.
    task automatic cyc();
        drive_fifo();
        @(posedge clock);
        model_step();
        #1;
    endtask

    always @(negedge clock) begin : compare
        bit need;
        if (model_live) begin
            need = autopull_en && (m_count >= eff(thresh));
            check("tx_ready", 32'(tx_ready), 32'(reset && need));
            check("stall", 32'(stall), 32'(m_pending && need));
            check("shift_count", 32'(shift_count), 32'(m_count));
            check("out_valid", 32'(out_valid), 32'(m_out_valid));
            check("out_data", out_data, m_out_data);
            if (out_valid === 1'b1) begin
                cap_data.push_back(out_data);
                cap_cnt.push_back(int'(shift_count));
            end
        end
    end

    initial begin
        reset = 1'b0; tick = 1'b0; clear = 1'b0; shift_dir = 1'b0;
        out_bits = 6'd8; autopull_en = 1'b0; thresh = 6'd0;
        tx_data = 32'd0; tx_valid = 1'b0;

        // Reset held low with tick toggling.
        for (int i = 0; i < 3; i++) begin
            tick = (i % 2 == 0);
            cyc();
        end
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_shift_count", 32'(shift_count), 32'd32);
        check("rst_tx_ready", 32'(tx_ready), 32'd0);
        tick = 1'b0; reset = 1'b1; autopull_en = 1'b1; thresh = 6'd0;
        #1;
        check("post_rst_tx_ready", 32'(tx_ready), 32'd1);

        // Left shift, 8 bits per tick.
        thresh = 6'd32; out_bits = 6'd8; shift_dir = 1'b0; valid_gate = 1'b1;
        fifo.push_back(32'hA1B2C3D4);
        cyc(); cyc();
        cap_data.delete(); cap_cnt.delete();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
        fifo.push_back(32'h11223344);
        tick = 1'b1; cyc();
        tick = 1'b0; cyc(); cyc(); cyc();
        check("left_strobes", 32'(cap_data.size()), 32'd5);
        if (cap_data.size() == 5) begin
            check("left_b0", cap_data[0], 32'hA1);
            check("left_b1", cap_data[1], 32'hB2);
            check("left_b2", cap_data[2], 32'hC3);
            check("left_b3", cap_data[3], 32'hD4);
            check("left_cnt0", 32'(cap_cnt[0]), 32'd8);
            check("left_cnt3", 32'(cap_cnt[3]), 32'd32);
            check("refill_b0", cap_data[4], 32'h11);
        end

        // Right shift, 1 bit per tick, through a whole word.
        clear = 1'b1; cyc(); clear = 1'b0;
        shift_dir = 1'b1; out_bits = 6'd1;
        fifo.push_back(32'h00000005);
        cyc(); cyc();
        cap_data.delete(); cap_cnt.delete();
        tick = 1'b1;
        repeat (40) cyc();
        tick = 1'b0; cyc(); cyc();
        check("right_strobes", 32'(cap_data.size()), 32'd32);
        if (cap_data.size() == 32) begin
            check("right_b0", cap_data[0], 32'd1);
            check("right_b1", cap_data[1], 32'd0);
            check("right_b2", cap_data[2], 32'd1);
            check("right_b3", cap_data[3], 32'd0);
            check("right_cnt31", 32'(cap_cnt[31]), 32'd32);
        end

        // Empty FIFO stall with merged ticks.
        shift_dir = 1'b0; out_bits = 6'd32;
        cap_data.delete(); cap_cnt.delete();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        tick = 1'b1; cyc(); cyc();
        tick = 1'b0; cyc(); cyc();
        check("stall_wait", 32'(stall), 32'd1);
        fifo.push_back(32'hCAFEF00D);
        repeat (5) cyc();
        check("stall_strobes", 32'(cap_data.size()), 32'd1);
        if (cap_data.size() == 1) check("stall_word", cap_data[0], 32'hCAFEF00D);
        check("stall_released", 32'(stall), 32'd0);

        // Full-width shift, then an exhausted OSR with autopull off.
        out_bits = 6'd0; thresh = 6'd0;
        fifo.push_back(32'hDEADBEEF);
        cyc(); cyc();
        cap_data.delete(); cap_cnt.delete();
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        check("full_shift_count", 32'(shift_count), 32'd32);
        autopull_en = 1'b0;
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        check("full_strobes", 32'(cap_data.size()), 32'd2);
        if (cap_data.size() == 2) begin
            check("full_word", cap_data[0], 32'hDEADBEEF);
            check("empty_word", cap_data[1], 32'd0);
        end

        // Clear coincident with a tick while a request is pending.
        autopull_en = 1'b1;
        tick = 1'b1; cyc();
        tick = 1'b0; cyc();
        check("pending_stall", 32'(stall), 32'd1);
        cap_data.delete(); cap_cnt.delete();
        clear = 1'b1; tick = 1'b1; cyc();
        clear = 1'b0; tick = 1'b0;
        check("clear_shift_count", 32'(shift_count), 32'd32);
        check("clear_stall", 32'(stall), 32'd0);
        check("clear_tx_ready", 32'(tx_ready), 32'd1);
        cyc(); cyc();
        check("clear_no_strobe", 32'(cap_data.size()), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if (i % 16 == 0) begin
                shift_dir   = 1'($urandom_range(0, 1));
                out_bits    = 6'($urandom_range(0, 39));
                thresh      = 6'($urandom_range(0, 39));
                autopull_en = ($urandom_range(0, 7) != 0);
            end
            tick       = ($urandom_range(0, 2) == 0);
            clear      = ($urandom_range(0, 96) == 0);
            reset      = ($urandom_range(0, 612) != 0);
            valid_gate = ($urandom_range(0, 3) != 0);
            if (fifo.size() < 3 && $urandom_range(0, 2) == 0) fifo.push_back($urandom);
            cyc();
        end
        tick = 1'b0; clear = 1'b0; reset = 1'b1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule
